// File: rtl/sc_matrix_mult_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sc_pkg
// Description : Shared constants, FSM state type and width helper for the
//               stochastic matrix-multiply stream and its LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
package sc_pkg;

  // Taps 16,14,13,11 of a 16-bit Fibonacci LFSR, as a mask on state[15:0]
  localparam logic [15:0] c_LFSR_TAPS = 16'hB400;
  localparam logic [15:0] c_LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of an index over n items; never narrower than one bit
  function automatic int selWidth(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sc_matrix_mult_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : sc_matrix_mult_stream_if
// Description : Control, stream and readout bundle of the stochastic
//               matrix-multiply block. master = SNG/readout side,
//               slave = the multiply block.
// Revision    : 1.0 - initial release
// ============================================================================
interface sc_matrix_mult_stream_if #(
  parameter int BATCH_SIZE      = 4,
  parameter int INPUT_FEATURES  = 4,
  parameter int OUTPUT_FEATURES = 4,
  parameter int STREAM_LEN_LOG2 = 8
) ();

  logic                                                         start;
  logic                                                         bipolar;
  logic                                                         inputValid;
  logic [BATCH_SIZE*INPUT_FEATURES-1:0]                         inputData;
  logic [OUTPUT_FEATURES*INPUT_FEATURES-1:0]                    weightData;
  logic [BATCH_SIZE*OUTPUT_FEATURES-1:0]                        outputStream;
  logic                                                         outputValid;
  logic [BATCH_SIZE*OUTPUT_FEATURES*(STREAM_LEN_LOG2+1)-1:0]    countData;
  logic                                                         busy;
  logic                                                         done;

  modport master (
    output start, bipolar, inputValid, inputData, weightData,
    input  outputStream, outputValid, countData, busy, done
  );

  modport slave (
    input  start, bipolar, inputValid, inputData, weightData,
    output outputStream, outputValid, countData, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/sc_matrix_mult_stream_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : sc_lfsr16
// Description : 16-bit Fibonacci LFSR (taps 16,14,13,11), shift-left with
//               feedback into bit 0. Shared with the number generators.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_lfsr16
  import sc_pkg::*;
#(
  parameter logic [15:0] RESET_SEED = c_LFSR_SEED
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        load,
  input  wire logic [15:0] seed,
  input  wire logic        enable,
  output logic      [15:0] state
);

  logic w_feedback;

  assign w_feedback = ^(state & c_LFSR_TAPS);

  // Reload has priority over stepping so a restart always begins at the seed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_SEED;
    end else if (load) begin
      state <= seed;
    end else if (enable) begin
      state <= {state[14:0], w_feedback};
    end
  end

endmodule
`default_nettype wire

// File: rtl/sc_matrix_mult_stream.sv
`default_nettype none
// ============================================================================
// Module      : sc_matrix_mult_stream
// Description : Stochastic C = A x B(T) over a 2^STREAM_LEN_LOG2 bitstream.
//               AND/XNOR products, LFSR-driven MUX scaled add, per-output
//               ones-counters for binary readout.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_matrix_mult_stream
  import sc_pkg::*;
#(
  parameter int          BATCH_SIZE      = 4,
  parameter int          INPUT_FEATURES  = 4,
  parameter int          OUTPUT_FEATURES = 4,
  parameter int          STREAM_LEN_LOG2 = 8,
  parameter logic [15:0] LFSR_SEED       = c_LFSR_SEED
) (
  input wire logic              clk,
  input wire logic              rst_n,
  sc_matrix_mult_stream_if.slave bus
);

  localparam int c_SEL_W = selWidth(INPUT_FEATURES);
  localparam int c_CNT_W = STREAM_LEN_LOG2 + 1;
  localparam int c_OUTS  = BATCH_SIZE * OUTPUT_FEATURES;

  state_t                     r_state;
  state_t                     w_stateNext;
  logic                       w_load;
  logic                       w_accept;
  logic                       w_last;
  logic                       r_mode;
  logic [STREAM_LEN_LOG2-1:0] r_cycleCnt;
  logic [15:0]                w_lfsrState;
  logic [c_SEL_W-1:0]         w_sel;
  logic [c_OUTS-1:0]          w_streamBit;
  logic [c_OUTS-1:0]          r_stream;
  logic                       r_outValid;
  logic                       r_done;
  logic [c_CNT_W-1:0]         r_count [c_OUTS];
  logic                       w_unusedLfsr;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state plus the load/accept/last strobes that steer the datapath
  always_comb begin
    w_stateNext = r_state;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_stateNext = RUN;
        end
      end
      RUN: begin
        if (bus.inputValid) begin
          w_accept = 1'b1;
          if (&r_cycleCnt) begin
            w_last      = 1'b1;
            w_stateNext = DONE;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // The select LFSR only steps on accepted bits, so stalls do not skew the MUX
  sc_lfsr16 #(
    .RESET_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_load),
    .seed   (LFSR_SEED),
    .enable (w_accept),
    .state  (w_lfsrState)
  );

  assign w_sel        = w_lfsrState[c_SEL_W-1:0];
  assign w_unusedLfsr = ^w_lfsrState;

  // Product terms and the shared-select MUX for every C element
  for (genvar m = 0; m < BATCH_SIZE; m++) begin : g_row
    for (genvar o = 0; o < OUTPUT_FEATURES; o++) begin : g_col
      logic [INPUT_FEATURES-1:0] w_a;
      logic [INPUT_FEATURES-1:0] w_b;
      logic [INPUT_FEATURES-1:0] w_prod;
      assign w_a    = bus.inputData[m*INPUT_FEATURES +: INPUT_FEATURES];
      assign w_b    = bus.weightData[o*INPUT_FEATURES +: INPUT_FEATURES];
      assign w_prod = r_mode ? ~(w_a ^ w_b) : (w_a & w_b);
      assign w_streamBit[m*OUTPUT_FEATURES+o] = w_prod[w_sel];
    end
  end

  // Mode latch, cycle counter, registered stream and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= 1'b0;
      r_cycleCnt <= '0;
      r_stream   <= '0;
      r_outValid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_outValid <= w_accept;
      r_done     <= w_last;
      if (w_load) begin
        r_mode     <= bus.bipolar;
        r_cycleCnt <= '0;
      end else if (w_accept) begin
        r_cycleCnt <= r_cycleCnt + STREAM_LEN_LOG2'(1);
        r_stream   <= w_streamBit;
      end
    end
  end

  // Ones-counters; one extra bit so a full-length all-ones stream reads L
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < c_OUTS; k++) r_count[k] <= '0;
    end else if (w_load) begin
      for (int k = 0; k < c_OUTS; k++) r_count[k] <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < c_OUTS; k++) r_count[k] <= r_count[k] + c_CNT_W'(w_streamBit[k]);
    end
  end

  // Pack the counters onto the readout bus
  always_comb begin
    bus.countData = '0;
    for (int k = 0; k < c_OUTS; k++) bus.countData[k*c_CNT_W +: c_CNT_W] = r_count[k];
  end

  assign bus.outputStream = r_stream;
  assign bus.outputValid  = r_outValid;
  assign bus.busy         = (r_state == RUN);
  assign bus.done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sc_matrix_mult_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_matrix_mult_stream
// Description : Self-checking bench for sc_matrix_mult_stream with a
//               behavioural stream/count model (L = 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_matrix_mult_stream;

  localparam int M  = 4;
  localparam int N  = 4;
  localparam int O  = 4;
  localparam int SL = 4;
  localparam int L  = 1 << SL;
  localparam int K  = M * O;
  localparam int W  = SL + 1;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [M*N-1:0] aSeq [L];
  logic [O*N-1:0] bSeq [L];
  logic [K-1:0]   expStream;

  sc_matrix_mult_stream_if #(
    .BATCH_SIZE(M), .INPUT_FEATURES(N), .OUTPUT_FEATURES(O), .STREAM_LEN_LOG2(SL)
  ) bus ();

  sc_matrix_mult_stream #(
    .BATCH_SIZE(M), .INPUT_FEATURES(N), .OUTPUT_FEATURES(O),
    .STREAM_LEN_LOG2(SL), .LFSR_SEED(SEED)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next LFSR value: shift left, new bit 0 = XOR of stages 16,14,13,11
  function automatic logic [15:0] lfsrStep(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  // C[m][o] stream bit = product of A[m][sel] and B[sel][o]
  function automatic logic [K-1:0] modelBits(input logic [M*N-1:0] a, input logic [O*N-1:0] b,
                                             input int sel, input bit bip);
    logic [K-1:0] r;
    logic av, bv;
    r = '0;
    for (int m = 0; m < M; m++) begin
      for (int o = 0; o < O; o++) begin
        av = a[m*N+sel];
        bv = b[o*N+sel];
        r[m*O+o] = bip ? (av == bv) : (av & bv);
      end
    end
    return r;
  endfunction

  task automatic fillConst(input logic [M*N-1:0] a, input logic [O*N-1:0] b);
    for (int i = 0; i < L; i++) begin
      aSeq[i] = a;
      bSeq[i] = b;
    end
  endtask

  task automatic fillRand();
    for (int i = 0; i < L; i++) begin
      aSeq[i] = (M*N)'($urandom);
      bSeq[i] = (O*N)'($urandom);
    end
  endtask

  // One stream: start, feed nAcc accepted bits (optionally stalling every
  // other cycle, optionally raising start mid-run), check every cycle.
  task automatic runStream(input string tag, input bit bip, input bit stall,
                           input int startAt, input int nAcc);
    logic [15:0]    lf;
    int             acc;
    int             cyc;
    int             sel;
    int             expCnt [K];
    bit             v;
    logic [K*W-1:0] ev;
    lf  = SEED;
    acc = 0;
    cyc = 0;
    for (int k = 0; k < K; k++) expCnt[k] = 0;

    // Start cycle also presents a valid bit, which must not be consumed
    @(negedge clk);
    bus.start      = 1'b1;
    bus.bipolar    = bip;
    bus.inputValid = 1'b1;
    bus.inputData  = (M*N)'($urandom);
    bus.weightData = (O*N)'($urandom);
    @(posedge clk); #1;
    chk({tag, "_busyAtStart"}, bus.busy, 1);
    chk({tag, "_ovAtStart"}, bus.outputValid, 0);
    chk({tag, "_streamAtStart"}, bus.outputStream, expStream);

    while (acc < nAcc) begin
      @(negedge clk);
      v              = stall ? (cyc % 2 == 0) : 1'b1;
      bus.start      = (cyc == startAt);
      bus.bipolar    = ~bip;
      bus.inputValid = v;
      bus.inputData  = v ? aSeq[acc] : (M*N)'($urandom);
      bus.weightData = v ? bSeq[acc] : (O*N)'($urandom);
      @(posedge clk); #1;
      if (v) begin
        sel       = int'(lf) % N;
        expStream = modelBits(aSeq[acc], bSeq[acc], sel, bip);
        for (int k = 0; k < K; k++) expCnt[k] += int'(expStream[k]);
        lf  = lfsrStep(lf);
        acc++;
      end
      chk({tag, "_stream"}, bus.outputStream, expStream);
      chk({tag, "_outValid"}, bus.outputValid, v);
      chk({tag, "_done"}, bus.done, (v && acc == L));
      chk({tag, "_busy"}, bus.busy, (acc != L));
      cyc++;
    end

    if (nAcc == L) begin
      for (int k = 0; k < K; k++) ev[k*W +: W] = W'(expCnt[k]);
      chk({tag, "_countFinal"}, bus.countData, ev);
      // DONE: further valid bits ignored, counts held, done was a single pulse
      @(negedge clk);
      bus.start      = 1'b0;
      bus.inputValid = 1'b1;
      bus.inputData  = (M*N)'($urandom);
      bus.weightData = (O*N)'($urandom);
      @(posedge clk); #1;
      chk({tag, "_donePulse"}, bus.done, 0);
      chk({tag, "_busyDone"}, bus.busy, 0);
      chk({tag, "_ovDone"}, bus.outputValid, 0);
      chk({tag, "_countHeld"}, bus.countData, ev);
      chk({tag, "_streamHeld"}, bus.outputStream, expStream);
    end
    bus.start      = 1'b0;
    bus.inputValid = 1'b0;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.bipolar    = 1'b0;
    bus.inputValid = 1'b0;
    bus.inputData  = '0;
    bus.weightData = '0;
    expStream      = '0;
    rst_n          = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_outValid", bus.outputValid, 0);
    chk("rst_count", bus.countData, 0);
    chk("rst_stream", bus.outputStream, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Unipolar corner patterns
    fillConst('1, '1);
    runStream("uniOnes", 1'b0, 1'b0, -1, L);
    fillConst('0, '1);
    runStream("uniZeroA", 1'b0, 1'b0, -1, L);
    fillConst((M*N)'(1), '1);
    runStream("uniA00", 1'b0, 1'b0, -1, L);

    // Random data, then the same data with every other cycle stalled
    fillRand();
    runStream("uniRand", 1'b0, 1'b0, -1, L);
    runStream("uniRandStall", 1'b0, 1'b1, -1, L);

    // Bipolar corner patterns and random data with a mid-run start
    fillConst('0, '0);
    runStream("bipZeros", 1'b1, 1'b0, -1, L);
    fillConst('1, '0);
    runStream("bipOnesZeros", 1'b1, 1'b0, -1, L);
    fillRand();
    runStream("bipRandStartMid", 1'b1, 1'b0, 5, L);

    // Reset after 7 accepted bits, then a clean full run
    fillRand();
    runStream("preReset", 1'b0, 1'b0, -1, 7);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    expStream = '0;
    chk("midRst_busy", bus.busy, 0);
    chk("midRst_done", bus.done, 0);
    chk("midRst_outValid", bus.outputValid, 0);
    chk("midRst_count", bus.countData, 0);
    chk("midRst_stream", bus.outputStream, 0);
    @(negedge clk);
    rst_n = 1'b1;
    runStream("postReset", 1'b0, 1'b0, -1, L);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
